// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master FSM state encoding.
// Also intended for reuse by the slave side of the AXI-to-APB bridge.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_e;

endpackage

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: turns single-outstanding cmd/rsp requests into AXI4-Lite transactions.
// Optional error counter output enabled by defining AXI_LITE_MASTER_ERR_CNT_EN.
module axi4_lite_master
  import axi_lite_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_WIDTH-1:0] WSTRB,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
`ifdef AXI_LITE_MASTER_ERR_CNT_EN
  ,
  output logic [15:0]           err_count
`endif
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    aw_done_q, w_done_q;
  logic                    rsp_write_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]              rsp_resp_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // AW and W may complete in the same cycle or in either order; a flag stands in for a handshake already done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = cmd_write ? WR : RD_ADDR;
      WR:      if ((aw_done_q | AWREADY) & (w_done_q | WREADY)) state_d = WR_RESP;
      WR_RESP: if (BVALID) state_d = RSP;
      RD_ADDR: if (ARREADY) state_d = RD_DATA;
      RD_DATA: if (RVALID) state_d = RSP;
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE:    cmd_ready = 1'b1;
      WR: begin
        AWVALID = ~aw_done_q;
        WVALID  = ~w_done_q;
      end
      WR_RESP: BREADY    = 1'b1;
      RD_ADDR: ARVALID   = 1'b1;
      RD_DATA: RREADY    = 1'b1;
      RSP:     rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request fields are captured once at command accept, so they stay stable for the whole transaction.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        WR: begin
          if (AWREADY) aw_done_q <= 1'b1;
          if (WREADY)  w_done_q  <= 1'b1;
        end
        WR_RESP: begin
          if (BVALID) begin
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= BRESP;
          end
        end
        RD_DATA: begin
          if (RVALID) begin
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= RDATA;
            rsp_resp_q  <= RRESP;
          end
        end
        default: ;
      endcase
    end
  end

  assign AWADDR    = addr_q;
  assign ARADDR    = addr_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

`ifdef AXI_LITE_MASTER_ERR_CNT_EN
  logic [15:0] err_count_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      err_count_q <= '0;
    end else if ((state_q == RSP) && rsp_ready && (rsp_resp_q != RESP_OKAY)
                 && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed self-checking bench for axi4_lite_master; the slave side is driven cycle by cycle.
// Inputs change and outputs are sampled on the falling edge of ACLK.
module tb_axi4_lite_master;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_write, cmd_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;
`ifdef AXI_LITE_MASTER_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  int compareCount  = 0;
  int mismatchCount = 0;

  axi4_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
`ifdef AXI_LITE_MASTER_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepCycle();
    @(negedge ACLK);
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " cmd_ready"}, 32'(cmd_ready), 32'h1);
    checkOutput({tag, " AWVALID"},   32'(AWVALID),   32'h0);
    checkOutput({tag, " WVALID"},    32'(WVALID),    32'h0);
    checkOutput({tag, " BREADY"},    32'(BREADY),    32'h0);
    checkOutput({tag, " ARVALID"},   32'(ARVALID),   32'h0);
    checkOutput({tag, " RREADY"},    32'(RREADY),    32'h0);
    checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'h0);
  endtask

  // Zero-wait write from IDLE; returns with the DUT presenting its response.
  task automatic zeroWaitWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic [1:0] br);
    applyStimulus(1'b1, 1'b1, a, d, s);
    AWREADY = 1'b1; WREADY = 1'b1;
    stepCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    BVALID = 1'b1; BRESP = br;
    stepCycle();
    AWREADY = 1'b0; WREADY = 1'b0;
    stepCycle();
    BVALID = 1'b0; BRESP = 2'b00;
  endtask

  task automatic zeroWaitRead(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rr);
    applyStimulus(1'b1, 1'b0, a, 32'h0, 4'h0);
    ARREADY = 1'b1;
    stepCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    stepCycle();
    ARREADY = 1'b0;
    RVALID = 1'b1; RDATA = d; RRESP = rr;
    stepCycle();
    RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00;
  endtask

  task automatic consumeResponse();
    rsp_ready = 1'b1;
    stepCycle();
    rsp_ready = 1'b0;
  endtask

  initial begin
    ARESET = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rsp_ready = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00;
    stepCycle();
    stepCycle();
    ARESET = 1'b0;
    checkIdleOutputs("reset");
    checkOutput("reset rsp_resp",  32'(rsp_resp),  32'h0);
    checkOutput("reset rsp_rdata", rsp_rdata,      32'h0);
`ifdef AXI_LITE_MASTER_ERR_CNT_EN
    checkOutput("reset err_count", 32'(err_count), 32'h0);
`endif

    // Zero-wait write with step-by-step latency checks.
    applyStimulus(1'b1, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
    AWREADY = 1'b1; WREADY = 1'b1;
    stepCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("wr1 cmd_ready", 32'(cmd_ready), 32'h0);
    checkOutput("wr1 AWVALID",   32'(AWVALID),   32'h1);
    checkOutput("wr1 WVALID",    32'(WVALID),    32'h1);
    checkOutput("wr1 AWADDR",    AWADDR,         32'h0000_0004);
    checkOutput("wr1 WDATA",     WDATA,          32'hDEAD_BEEF);
    checkOutput("wr1 WSTRB",     32'(WSTRB),     32'hF);
    checkOutput("wr1 BREADY",    32'(BREADY),    32'h0);
    BVALID = 1'b1; BRESP = 2'b00;
    stepCycle();
    AWREADY = 1'b0; WREADY = 1'b0;
    checkOutput("wr1 AWVALID after hs", 32'(AWVALID), 32'h0);
    checkOutput("wr1 WVALID after hs",  32'(WVALID),  32'h0);
    checkOutput("wr1 BREADY",           32'(BREADY),  32'h1);
    checkOutput("wr1 rsp_valid early",  32'(rsp_valid), 32'h0);
    stepCycle();
    BVALID = 1'b0;
    checkOutput("wr1 rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("wr1 rsp_write", 32'(rsp_write), 32'h1);
    checkOutput("wr1 rsp_resp",  32'(rsp_resp),  32'h0);
    checkOutput("wr1 rsp_rdata", rsp_rdata,      32'h0);
    checkOutput("wr1 BREADY off", 32'(BREADY),   32'h0);
    consumeResponse();
    checkIdleOutputs("wr1 done");

    // Read with ARREADY held off for three cycles; a stray R must not be taken early.
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    RVALID = 1'b1; RDATA = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      checkOutput("rd ARVALID wait", 32'(ARVALID), 32'h1);
      checkOutput("rd ARADDR wait",  ARADDR,       32'h0000_0010);
      checkOutput("rd RREADY wait",  32'(RREADY),  32'h0);
      stepCycle();
    end
    RVALID = 1'b0; RDATA = 32'h0;
    ARREADY = 1'b1;
    checkOutput("rd ARVALID at hs", 32'(ARVALID), 32'h1);
    stepCycle();
    ARREADY = 1'b0;
    checkOutput("rd ARVALID after hs", 32'(ARVALID), 32'h0);
    checkOutput("rd RREADY",           32'(RREADY),  32'h1);
    RVALID = 1'b1; RDATA = 32'h1234_5678; RRESP = 2'b00;
    stepCycle();
    RVALID = 1'b0; RDATA = 32'h0;
    checkOutput("rd rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("rd rsp_rdata", rsp_rdata,      32'h1234_5678);
    checkOutput("rd rsp_resp",  32'(rsp_resp),  32'h0);
    checkOutput("rd rsp_write", 32'(rsp_write), 32'h0);
    consumeResponse();

    // Skewed write: W completes in the first cycle, AW only in the fourth.
    applyStimulus(1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_5A5A, 4'h3);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    WREADY = 1'b1;
    checkOutput("skew c1 AWVALID", 32'(AWVALID), 32'h1);
    checkOutput("skew c1 WVALID",  32'(WVALID),  32'h1);
    stepCycle();
    WREADY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput("skew WVALID dropped", 32'(WVALID),  32'h0);
      checkOutput("skew AWVALID held",   32'(AWVALID), 32'h1);
      checkOutput("skew BREADY early",   32'(BREADY),  32'h0);
      stepCycle();
    end
    AWREADY = 1'b1;
    checkOutput("skew c4 AWVALID", 32'(AWVALID), 32'h1);
    checkOutput("skew c4 AWADDR",  AWADDR,       32'h0000_0020);
    checkOutput("skew c4 BREADY",  32'(BREADY),  32'h0);
    stepCycle();
    AWREADY = 1'b0;
    checkOutput("skew AWVALID after hs", 32'(AWVALID), 32'h0);
    checkOutput("skew BREADY",           32'(BREADY),  32'h1);
    BVALID = 1'b1;
    stepCycle();
    BVALID = 1'b0;
    checkOutput("skew rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("skew rsp_write", 32'(rsp_write), 32'h1);
    consumeResponse();

    // Error responses are passed through unchanged.
    zeroWaitWrite(32'h0000_0040, 32'h1111_2222, 4'h1, 2'b10);
    checkOutput("err wr rsp_resp",  32'(rsp_resp),  32'h2);
    checkOutput("err wr rsp_write", 32'(rsp_write), 32'h1);
    consumeResponse();
    zeroWaitRead(32'h0000_0044, 32'h5555_AAAA, 2'b11);
    checkOutput("err rd rsp_resp",  32'(rsp_resp),  32'h3);
    checkOutput("err rd rsp_rdata", rsp_rdata,      32'h5555_AAAA);
    consumeResponse();
`ifdef AXI_LITE_MASTER_ERR_CNT_EN
    checkOutput("err_count", 32'(err_count), 32'h2);
`endif

    // Response backpressure with a second command already waiting.
    zeroWaitRead(32'h0000_0050, 32'hCAFE_0001, 2'b00);
    applyStimulus(1'b1, 1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'hC);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp rsp_valid", 32'(rsp_valid), 32'h1);
      checkOutput("bp rsp_rdata", rsp_rdata,      32'hCAFE_0001);
      checkOutput("bp cmd_ready", 32'(cmd_ready), 32'h0);
      checkOutput("bp AWVALID",   32'(AWVALID),   32'h0);
      stepCycle();
    end
    consumeResponse();
    checkOutput("bp after rsp cmd_ready", 32'(cmd_ready), 32'h1);
    checkOutput("bp after rsp AWVALID",   32'(AWVALID),   32'h0);
    checkOutput("bp after rsp rsp_valid", 32'(rsp_valid), 32'h0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("bp 2nd AWVALID", 32'(AWVALID), 32'h1);
    checkOutput("bp 2nd AWADDR",  AWADDR,       32'h0000_0030);
    checkOutput("bp 2nd WDATA",   WDATA,        32'h0BAD_F00D);
    AWREADY = 1'b1; WREADY = 1'b1;
    stepCycle();
    AWREADY = 1'b0; WREADY = 1'b0;
    BVALID = 1'b1;
    stepCycle();
    BVALID = 1'b0;
    checkOutput("bp 2nd rsp_valid", 32'(rsp_valid), 32'h1);
    consumeResponse();

    // Reset while waiting for B abandons the write.
    zeroWaitWrite(32'h0000_0060, 32'h7777_8888, 4'hF, 2'b10);
    consumeResponse();
    applyStimulus(1'b1, 1'b1, 32'h0000_0064, 32'h9999_0000, 4'hF);
    AWREADY = 1'b1; WREADY = 1'b1;
    stepCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    stepCycle();
    AWREADY = 1'b0; WREADY = 1'b0;
    checkOutput("rst WR_RESP BREADY", 32'(BREADY), 32'h1);
    ARESET = 1'b1;
    stepCycle();
    ARESET = 1'b0;
    checkIdleOutputs("rst mid");
    checkOutput("rst mid rsp_resp", 32'(rsp_resp), 32'h0);
`ifdef AXI_LITE_MASTER_ERR_CNT_EN
    checkOutput("rst err_count", 32'(err_count), 32'h0);
`endif
    BVALID = 1'b1; BRESP = 2'b01;
    checkOutput("rst stray B BREADY", 32'(BREADY), 32'h0);
    stepCycle();
    BVALID = 1'b0; BRESP = 2'b00;
    checkOutput("rst no rsp_valid", 32'(rsp_valid), 32'h0);
    zeroWaitRead(32'h0000_0070, 32'h89AB_CDEF, 2'b00);
    checkOutput("post rst rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("post rst rsp_rdata", rsp_rdata,      32'h89AB_CDEF);
    checkOutput("post rst rsp_resp",  32'(rsp_resp),  32'h0);
    consumeResponse();
    checkOutput("post rst cmd_ready", 32'(cmd_ready), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
